// File: rtl/serial_port.sv
// rtl/serial_port.sv - 8N1 UART between the memory controller serial-port handshake and the RS-232 pins
module serial_port #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    output logic       com_write_ready,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    input  logic       int_com_ack,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       frame_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [11:0] DIV_LAST  = 12'(CLK_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(CLK_DIV / 2 - 1);

    logic [1:0]  tx_state;
    logic [11:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;

    logic [1:0]  rx_state;
    logic [11:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_m;
    logic        rx_s;
    logic        rx_p;

    // tx_shift[0] is always the bit currently on the line during DATA
    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            tx_state        <= ST_IDLE;
            tx_cnt          <= '0;
            tx_idx          <= '0;
            tx_shift        <= '0;
            uart_tx         <= 1'b1;
            com_write_ready <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (enable_com_write) begin
                        tx_shift        <= com_data_out;
                        tx_cnt          <= '0;
                        tx_state        <= ST_START;
                        uart_tx         <= 1'b0;
                        com_write_ready <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= ST_DATA;
                        uart_tx  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 12'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            uart_tx  <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 12'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt          <= '0;
                        tx_state        <= ST_IDLE;
                        com_write_ready <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 12'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // The ack clear comes first so a byte committing on the same edge keeps ready high
    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            rx_state       <= ST_IDLE;
            rx_cnt         <= '0;
            rx_idx         <= '0;
            rx_shift       <= '0;
            com_data_in    <= '0;
            com_read_ready <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (int_com_ack) begin
                com_read_ready <= 1'b0;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (rx_p && !rx_s) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        if (rx_s) begin
                            com_data_in    <= rx_shift;
                            com_read_ready <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_port.sv
// tb/tb_serial_port.sv - directed self-checking bench for serial_port at CLK_DIV=8
module tb_serial_port;

    logic       clk50M = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] com_data_out = 8'h00;
    logic       enable_com_write = 1'b0;
    logic       com_write_ready;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       int_com_ack = 1'b0;
    logic       uart_tx;
    logic       frame_error;
    logic       rx_drv = 1'b1;
    logic       loopback = 1'b0;
    wire        uart_rx;

    int total = 0;
    int bad = 0;
    int rise_at;
    int fe_cnt;

    assign uart_rx = loopback ? uart_tx : rx_drv;

    serial_port #(.CLK_DIV(8)) dut (
        .clk50M          (clk50M),
        .rst_n           (rst_n),
        .com_data_out    (com_data_out),
        .enable_com_write(enable_com_write),
        .com_write_ready (com_write_ready),
        .com_data_in     (com_data_in),
        .com_read_ready  (com_read_ready),
        .int_com_ack     (int_com_ack),
        .uart_rx         (uart_rx),
        .uart_tx         (uart_tx),
        .frame_error     (frame_error)
    );

    always #5 clk50M = ~clk50M;

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame; iteration i is sampled by edge i+1, so the stop-bit commit lands on edge 79
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_at);
        logic [9:0] lv;
        logic       prev;
        lv = {stop_bit, b, 1'b0};
        prev = com_read_ready;
        rise_at = -1;
        fe_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            rx_drv = lv[i / 8];
            int_com_ack = (i == ack_at);
            tick();
            if (rise_at < 0 && com_read_ready && !prev) rise_at = i + 1;
            prev = com_read_ready;
            if (frame_error) fe_cnt++;
        end
        int_com_ack = 1'b0;
        rx_drv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (frame_error) fe_cnt++;
        end
    endtask

    initial begin
        logic [9:0] txf;
        int         lvl_ok [10];
        int         busy;
        int         n;
        int         rdy_seen;

        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_tx", int'(uart_tx), 1);
        check("rst_wr_ready", int'(com_write_ready), 1);
        check("rst_rd_ready", int'(com_read_ready), 0);
        check("rst_data_in", int'(com_data_in), 0);
        check("rst_frame_err", int'(frame_error), 0);

        txf = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) lvl_ok[j] = 0;
        busy = 0;
        com_data_out = 8'hA5;
        enable_com_write = 1'b1;
        tick();
        enable_com_write = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (uart_tx == txf[k / 8]) lvl_ok[k / 8]++;
            if (!com_write_ready) busy++;
            if (k == 20) begin
                com_data_out = 8'hFF;
                enable_com_write = 1'b1;
            end else begin
                enable_com_write = 1'b0;
            end
            tick();
        end
        enable_com_write = 1'b0;
        for (int j = 0; j < 10; j++) check($sformatf("tx_level%0d", j), lvl_ok[j], 8);
        check("tx_busy_cycles", busy, 80);
        check("tx_ready_after", int'(com_write_ready), 1);
        check("tx_idle_high", int'(uart_tx), 1);

        send_frame(8'h3C, 1'b1, -1);
        check("rx_rise_edge", rise_at, 79);
        check("rx_data", int'(com_data_in), 'h3C);
        check("rx_ready", int'(com_read_ready), 1);
        check("rx_no_fe", fe_cnt, 0);
        int_com_ack = 1'b1;
        tick();
        int_com_ack = 1'b0;
        check("ack_ready", int'(com_read_ready), 0);
        check("ack_data", int'(com_data_in), 'h3C);

        rdy_seen = 0;
        fe_cnt = 0;
        rx_drv = 1'b0;
        repeat (2) tick();
        rx_drv = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (com_read_ready) rdy_seen++;
            if (frame_error) fe_cnt++;
        end
        check("glitch_ready", rdy_seen, 0);
        check("glitch_fe", fe_cnt, 0);

        send_frame(8'h55, 1'b0, -1);
        check("ferr_pulses", fe_cnt, 1);
        check("ferr_ready", int'(com_read_ready), 0);
        check("ferr_data", int'(com_data_in), 'h3C);

        send_frame(8'h11, 1'b1, -1);
        check("ovr_first", int'(com_data_in), 'h11);
        send_frame(8'h22, 1'b1, -1);
        check("ovr_data", int'(com_data_in), 'h22);
        check("ovr_ready", int'(com_read_ready), 1);
        send_frame(8'h33, 1'b1, 78);
        check("simul_data", int'(com_data_in), 'h33);
        check("simul_ready", int'(com_read_ready), 1);

        int_com_ack = 1'b1;
        tick();
        int_com_ack = 1'b0;
        loopback = 1'b1;
        repeat (4) tick();
        com_data_out = 8'h7E;
        enable_com_write = 1'b1;
        tick();
        enable_com_write = 1'b0;
        n = 0;
        while (!com_read_ready && n < 200) begin
            tick();
            n++;
        end
        check("lb_ready", int'(com_read_ready), 1);
        check("lb_data", int'(com_data_in), 'h7E);
        repeat (4) tick();
        check("lb_wr_ready", int'(com_write_ready), 1);

        int_com_ack = 1'b1;
        tick();
        int_com_ack = 1'b0;
        com_data_out = 8'hE1;
        enable_com_write = 1'b1;
        tick();
        enable_com_write = 1'b0;
        repeat (39) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_tx", int'(uart_tx), 1);
        repeat (2) tick();
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (com_read_ready) rdy_seen++;
        end
        check("mid_rst_no_rx", rdy_seen, 0);
        check("mid_rst_data", int'(com_data_in), 0);
        check("mid_rst_wr_ready", int'(com_write_ready), 1);
        check("mid_rst_tx_idle", int'(uart_tx), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- UART end of the CPU serial-port interface; the memory controller is the other end.
- Accepts bytes on the com_data_out/enable_com_write handshake and serialises them 8N1 on uart_tx.
- Deserialises uart_rx into a one-byte holding register, exposed as com_data_in/com_read_ready and cleared by int_com_ack.
- Sits at board top level between the memory controller and the RS-232 pins.

Parameters:
- CLK_DIV, 434, clk50M cycles per bit (50 MHz / 115200). Legal range 8..4095; simulation uses 8.

Ports:
- clk50M  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- com_data_out  input  8  byte to transmit; sampled when enable_com_write=1.
- enable_com_write  input  1  one-cycle transmit request.
- com_write_ready  output  1  transmitter idle, a request will be accepted.
- com_data_in  output  8  last byte received.
- com_read_ready  output  1  com_data_in holds an unread byte.
- int_com_ack  input  1  CPU has read com_data_in; clears com_read_ready.
- uart_rx  input  1  serial input, asynchronous, idle high.
- uart_tx  output  1  serial output, idle high.
- frame_error  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset, while rst_n=0 at an edge:
  - Outputs: uart_tx=1, com_write_ready=1, com_read_ready=0, com_data_in=0, frame_error=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame; uart_tx returns high at that edge.
- TX FSM, states IDLE, START, DATA, STOP; baud counter 0..CLK_DIV-1; bit index 0..7.
  - IDLE:
    - com_write_ready=1, uart_tx=1.
    - On an edge with enable_com_write=1: latch com_data_out, go to START, zero the counter.
    - At that same edge uart_tx becomes 0 and com_write_ready becomes 0. Zero-cycle latency after the sampling edge, all outputs registered.
  - START: hold 0 for CLK_DIV cycles, then DATA.
  - DATA: send bits LSB first, each for CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles, then IDLE with com_write_ready=1.
  - Frame length is 10*CLK_DIV cycles from acceptance to com_write_ready rising.
  - enable_com_write while not in IDLE is ignored, with no queueing and no corruption of the current frame.
  - A request on the same edge that ready rises is not accepted; ready must be 1 before that edge.
- RX path:
  - uart_rx passes through a 2-flop synchroniser. rx_s is the synchronised value, rx_p is its previous value.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_p=1 and rx_s=0 enters START with counter 0.
  - START: at count CLK_DIV/2-1 (integer division), re-sample.
    - If rx_s=1 it was a glitch: return to IDLE with no output.
    - Otherwise reset the counter and go to DATA.
  - DATA: sample rx_s every CLK_DIV cycles, at mid-bit, into a shift register LSB first; 8 samples.
  - STOP: sample after CLK_DIV cycles.
    - rx_s=1: com_data_in<=shift register and com_read_ready<=1 on the same edge.
    - rx_s=0: frame_error=1 for one cycle, data discarded, com_data_in and com_read_ready unchanged.
    - Either way go to IDLE. A new start needs a fresh 1->0 transition, so a held-low line does not retrigger.
- Read handshake:
  - int_com_ack=1 at an edge clears com_read_ready; com_data_in keeps its value.
  - Overrun: a new valid byte while com_read_ready=1 overwrites com_data_in and ready stays 1. No overrun flag.
  - If ack and a new byte commit on the same edge, the new byte wins and com_read_ready=1.
  - Ack while com_read_ready=0 has no effect.
- TX and RX are fully independent; loopback (uart_tx tied to uart_rx) must work.

Test Plan (all with CLK_DIV=8):
- Reset: hold rst_n=0 for 3 cycles, then release -> uart_tx=1, com_write_ready=1, com_read_ready=0, com_data_in=8'h00.
- TX 8'hA5:
  - uart_tx shows 0,1,0,1,0,0,1,0,1,1, each level exactly 8 cycles.
  - com_write_ready=0 for 80 cycles, then 1.
  - A second enable pulse with 8'hFF at cycle 20 is ignored.
- RX 8'h3C:
  - Drive an 8N1 frame at 8 cycles/bit.
  - com_read_ready rises during the stop bit and com_data_in=8'h3C.
  - Pulse int_com_ack -> ready=0 next edge, data still 8'h3C.
- Glitch and framing:
  - A 2-cycle low pulse on uart_rx -> no ready and no frame_error.
  - Frame 8'h55 with stop bit 0 -> frame_error one-cycle pulse; ready and data unchanged.
- Overrun/simultaneous:
  - Receive 8'h11 without ack, then 8'h22 -> data=8'h22, ready=1.
  - Assert int_com_ack on the exact commit edge of 8'h33 -> ready=1, data=8'h33.
- Loopback with mid-frame reset:
  - Loop uart_tx to uart_rx, send 8'h7E -> received 8'h7E.
  - Assert rst_n=0 at cycle 40 of a frame -> uart_tx=1 at that edge, no byte received, com_write_ready=1 after release.
